// File: rtl/rgb_gray_stream_ctrl_if.sv
// Purpose : pixel stream bundle; RGB beats in (s_*), framed gray beats out (m_*).
// Latency : none, wires only.
// Backpressure: valid/ready on both sides; s_ready is driven by the controller.
// Ports   : slave  = controller view (consumes s_*, produces m_*);
//           master = environment view (source drives s_*, sink drives m_ready).
interface rgb_gray_stream_ctrl_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_r;
  logic [7:0] s_g;
  logic [7:0] s_b;
  logic       s_sof;
  logic       s_eof;

  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_gray;
  logic       m_sof;
  logic       m_eof;

  modport slave (
    input  s_valid, s_r, s_g, s_b, s_sof, s_eof, m_ready,
    output s_ready, m_valid, m_gray, m_sof, m_eof
  );

  modport master (
    output s_valid, s_r, s_g, s_b, s_sof, s_eof, m_ready,
    input  s_ready, m_valid, m_gray, m_sof, m_eof
  );
endinterface

// File: rtl/rgb_gray_stream_ctrl.sv
// Purpose : frames an RGB pixel stream, converts to brightness-adjusted 8-bit gray, keeps frame stats.
// Latency : 2 register stages (products, then sum/offset/clamp); 1 pixel/cycle when not stalled.
// Backpressure: both stages advance together only when the output slot is empty or being taken.
// Ports   : i_clk/i_rst (sync, active-high); i_cfg_level/i_cfg_we shadow level write;
//           px stream bundle (slave); o_busy, o_frame_cnt, o_last_frame_pixels,
//           o_drop_cnt, o_err_sof status.
module rgb_gray_stream_ctrl #(
  parameter int unsigned MAX_LEVEL = 10,
  parameter int unsigned STEP      = 20
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [3:0]                  i_cfg_level,
  input  logic                        i_cfg_we,
  rgb_gray_stream_ctrl_if.slave       px,
  output logic                        o_busy,
  output logic [15:0]                 o_frame_cnt,
  output logic [23:0]                 o_last_frame_pixels,
  output logic [15:0]                 o_drop_cnt,
  output logic                        o_err_sof
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_busy;

  logic [3:0]  r_shadow_level;
  logic [3:0]  r_active_level;
  logic [23:0] r_pix_cnt;
  logic [15:0] r_frame_cnt;
  logic [23:0] r_last_frame_pixels;
  logic [15:0] r_drop_cnt;
  logic        r_err_sof;

  // stage 1: weighted products plus per-pixel level and markers
  logic        r_s1_valid;
  logic [15:0] r_s1_mr;
  logic [15:0] r_s1_mg;
  logic [15:0] r_s1_mb;
  logic [3:0]  r_s1_level;
  logic        r_s1_sof;
  logic        r_s1_eof;

  // stage 2: output registers
  logic        r_m_valid;
  logic [7:0]  r_m_gray;
  logic        r_m_sof;
  logic        r_m_eof;

  logic        w_adv;
  logic        w_s_ready;
  logic        w_accept;
  logic        w_fwd;
  logic        w_drop;
  logic        w_frame_done;
  logic        w_sof_accept;
  logic [3:0]  w_cfg_clamped;
  logic [3:0]  w_new_active;
  logic [3:0]  w_pix_level;
  logic [23:0] w_pix_next;
  logic [15:0] w_mr;
  logic [15:0] w_mg;
  logic [15:0] w_mb;
  logic [7:0]  w_y;
  logic [8:0]  w_bright;
  logic [8:0]  w_t;
  logic [7:0]  w_gray;

  // The output slot frees up when empty or when the sink takes it this cycle.
  // s_ready is forced low while in reset so nothing is accepted on the reset edge.
  assign w_adv     = !r_m_valid || px.m_ready;
  assign w_s_ready = !i_rst && w_adv;
  assign w_accept  = px.s_valid && w_s_ready;

  // Any SOF beat is forwarded; non-SOF beats only inside a frame.
  assign w_sof_accept = w_accept && px.s_sof;
  assign w_fwd        = w_accept && (px.s_sof || (r_state == ACTIVE));
  assign w_drop       = w_accept && !px.s_sof && (r_state == IDLE);
  assign w_frame_done = w_fwd && px.s_eof;

  // SOF always restarts the count, so a 1-pixel frame or an in-frame restart counts from 1.
  assign w_pix_next = px.s_sof ? 24'd1 : (r_pix_cnt + 24'd1);

  assign w_cfg_clamped = (i_cfg_level > 4'(MAX_LEVEL)) ? 4'(MAX_LEVEL) : i_cfg_level;
  // A config write landing on the SOF beat wins over the older shadow value.
  assign w_new_active  = i_cfg_we ? w_cfg_clamped : r_shadow_level;
  // The SOF pixel itself must already use the newly loaded level.
  assign w_pix_level   = w_sof_accept ? w_new_active : r_active_level;

  assign w_mr = 16'(px.s_r) * 16'd77;
  assign w_mg = 16'(px.s_g) * 16'd150;
  assign w_mb = 16'(px.s_b) * 16'd29;

  // Weights sum to 256, so the 16-bit sum tops out at 65280 and y never exceeds 255.
  assign w_y      = 8'((r_s1_mr + r_s1_mg + r_s1_mb) >> 8);
  assign w_bright = 9'(r_s1_level) * 9'(STEP);
  assign w_t      = {1'b0, w_y} + w_bright;
  assign w_gray   = w_t[8] ? 8'hFF : w_t[7:0];

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state; any forwarded beat decides the state from its EOF flag,
  // which also covers the 1-pixel SOF+EOF frame staying in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    if (w_fwd) begin
      w_state_nxt = px.s_eof ? IDLE : ACTIVE;
    end
    if (r_state == ACTIVE) begin
      w_busy = 1'b1;
    end
  end

  // Level, counters and status
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shadow_level      <= '0;
      r_active_level      <= '0;
      r_pix_cnt           <= '0;
      r_frame_cnt         <= '0;
      r_last_frame_pixels <= '0;
      r_drop_cnt          <= '0;
      r_err_sof           <= 1'b0;
    end else begin
      if (i_cfg_we) begin
        r_shadow_level <= w_cfg_clamped;
      end
      if (w_sof_accept) begin
        r_active_level <= w_new_active;
      end
      if (w_fwd) begin
        r_pix_cnt <= w_pix_next;
      end
      if (w_frame_done) begin
        r_frame_cnt         <= r_frame_cnt + 16'd1;
        r_last_frame_pixels <= w_pix_next;
      end
      if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
      if (w_sof_accept && (r_state == ACTIVE)) begin
        r_err_sof <= 1'b1;
      end
    end
  end

  // Two-stage datapath; both stages move in lockstep on w_adv and hold otherwise.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_mr    <= '0;
      r_s1_mg    <= '0;
      r_s1_mb    <= '0;
      r_s1_level <= '0;
      r_s1_sof   <= 1'b0;
      r_s1_eof   <= 1'b0;
      r_m_valid  <= 1'b0;
      r_m_gray   <= '0;
      r_m_sof    <= 1'b0;
      r_m_eof    <= 1'b0;
    end else if (w_adv) begin
      // a dropped IDLE beat leaves a bubble in stage 1
      r_s1_valid <= w_fwd;
      r_s1_mr    <= w_mr;
      r_s1_mg    <= w_mg;
      r_s1_mb    <= w_mb;
      r_s1_level <= w_pix_level;
      r_s1_sof   <= px.s_sof;
      r_s1_eof   <= px.s_eof;
      r_m_valid  <= r_s1_valid;
      r_m_gray   <= w_gray;
      r_m_sof    <= r_s1_sof;
      r_m_eof    <= r_s1_eof;
    end
  end

  assign px.s_ready          = w_s_ready;
  assign px.m_valid          = r_m_valid;
  assign px.m_gray           = r_m_gray;
  assign px.m_sof            = r_m_sof;
  assign px.m_eof            = r_m_eof;
  assign o_busy              = w_busy;
  assign o_frame_cnt         = r_frame_cnt;
  assign o_last_frame_pixels = r_last_frame_pixels;
  assign o_drop_cnt          = r_drop_cnt;
  assign o_err_sof           = r_err_sof;

endmodule

// File: tb/tb_rgb_gray_stream_ctrl.sv
// Purpose : directed bench for rgb_gray_stream_ctrl with an output scoreboard.
// Latency : expected beats queued on input acceptance, compared when the sink takes them.
// Backpressure: sink ready is driven by the sequence to create stalls.
module tb_rgb_gray_stream_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  cfg_level;
  logic        cfg_we;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [23:0] last_frame_pixels;
  logic [15:0] drop_cnt;
  logic        err_sof;

  rgb_gray_stream_ctrl_if dut_if ();

  rgb_gray_stream_ctrl #(.MAX_LEVEL(10), .STEP(20)) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_cfg_level         (cfg_level),
    .i_cfg_we            (cfg_we),
    .px                  (dut_if.slave),
    .o_busy              (busy),
    .o_frame_cnt         (frame_cnt),
    .o_last_frame_pixels (last_frame_pixels),
    .o_drop_cnt          (drop_cnt),
    .o_err_sof           (err_sof)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_out  = 0;
  logic [9:0] exp_q [$];   // {sof, eof, gray}

  // reference model of level handling and framing
  int m_shadow = 0;
  int m_active = 0;
  bit m_act    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [9:0] exp_px(input int r, input int g, input int b,
                                        input int lvl, input bit sof, input bit eof);
    int y;
    int t;
    y = (r * 77 + g * 150 + b * 29) / 256;
    t = y + lvl * 20;
    if (t > 255) t = 255;
    return {sof, eof, 8'(t)};
  endfunction

  // Output monitor: checks hold stability under stall and pops the scoreboard on transfer.
  logic [9:0] held;
  bit         hold_v = 1'b0;
  always @(negedge clk) begin
    logic [9:0] cur;
    logic [9:0] e;
    if (rst) begin
      hold_v = 1'b0;
    end else if (dut_if.m_valid) begin
      cur = {dut_if.m_sof, dut_if.m_eof, dut_if.m_gray};
      if (hold_v) chk("hold_stable", 32'(cur), 32'(held));
      if (dut_if.m_ready) begin
        hold_v = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'(cur), 32'h3FF);
        end else begin
          e = exp_q.pop_front();
          chk("out_pix", 32'(cur), 32'(e));
          n_out++;
        end
      end else begin
        held   = cur;
        hold_v = 1'b1;
      end
    end
  end

  // Present one beat (optionally with a coincident cfg write) until accepted.
  // Called and returns at 1 time unit after a rising edge.
  task automatic send(input int r, input int g, input int b, input bit sof, input bit eof,
                      input bit we = 1'b0, input int wl = 0);
    bit acc;
    int wc;
    dut_if.s_valid = 1'b1;
    dut_if.s_r     = 8'(r);
    dut_if.s_g     = 8'(g);
    dut_if.s_b     = 8'(b);
    dut_if.s_sof   = sof;
    dut_if.s_eof   = eof;
    cfg_we         = we;
    cfg_level      = 4'(wl);
    acc            = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (dut_if.s_ready) begin
        acc = 1'b1;
        break;
      end
    end
    if (acc) begin
      @(posedge clk);
      wc = (wl > 10) ? 10 : wl;
      if (sof) m_active = we ? wc : m_shadow;
      if (we) m_shadow = wc;
      if (sof || m_act) begin
        exp_q.push_back(exp_px(r, g, b, m_active, sof, eof));
        m_act = !eof;
      end
    end else begin
      chk("accept_timeout", 32'd0, 32'd1);
    end
    #1;
    dut_if.s_valid = 1'b0;
    cfg_we         = 1'b0;
  endtask

  task automatic cfg_write(input int l);
    cfg_level = 4'(l);
    cfg_we    = 1'b1;
    @(posedge clk);
    m_shadow = (l > 10) ? 10 : l;
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 60; c++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int out0;
    dut_if.s_valid = 1'b0;
    dut_if.s_r     = '0;
    dut_if.s_g     = '0;
    dut_if.s_b     = '0;
    dut_if.s_sof   = 1'b0;
    dut_if.s_eof   = 1'b0;
    dut_if.m_ready = 1'b1;
    cfg_level      = '0;
    cfg_we         = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", 32'(dut_if.s_ready), 32'd0);
    chk("rst_m_valid", 32'(dut_if.m_valid), 32'd0);
    chk("rst_m_gray", 32'(dut_if.m_gray), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_last_pix", 32'(last_frame_pixels), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("rst_err_sof", 32'(err_sof), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_s_ready", 32'(dut_if.s_ready), 32'd1);
    @(posedge clk);
    #1;

    // 1-pixel white frame at level 0; beat presented after edge k, out after edge k+2
    send(255, 255, 255, 1'b1, 1'b1);
    @(negedge clk);
    chk("lat_early_m_valid", 32'(dut_if.m_valid), 32'd0);
    @(negedge clk);
    chk("lat_m_valid", 32'(dut_if.m_valid), 32'd1);
    chk("lat_m_gray", 32'(dut_if.m_gray), 32'd255);
    @(posedge clk);
    #1;
    drain();
    chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("t1_last_pix", 32'(last_frame_pixels), 32'd1);

    // level 5, 3-pixel frame, y=82 -> 182
    cfg_write(5);
    send(100, 50, 200, 1'b1, 1'b0);
    chk("t2_busy_hi", 32'(busy), 32'd1);
    send(100, 50, 200, 1'b0, 1'b0);
    send(100, 50, 200, 1'b0, 1'b1);
    drain();
    chk("t2_busy_lo", 32'(busy), 32'd0);
    chk("t2_frame_cnt", 32'(frame_cnt), 32'd2);
    chk("t2_last_pix", 32'(last_frame_pixels), 32'd3);

    // level clamp and saturation; black pixel at level 3
    cfg_write(10);
    cfg_write(15);
    send(100, 50, 200, 1'b1, 1'b1);
    cfg_write(3);
    send(0, 0, 0, 1'b1, 1'b1);
    drain();
    chk("t3_frame_cnt", 32'(frame_cnt), 32'd4);

    // mid-frame level write affects only the next frame
    cfg_write(4);
    send(100, 50, 200, 1'b1, 1'b0);
    cfg_write(2);
    send(100, 50, 200, 1'b0, 1'b0);
    send(100, 50, 200, 1'b0, 1'b1);
    send(100, 50, 200, 1'b1, 1'b1);
    drain();
    chk("t4_frame_cnt", 32'(frame_cnt), 32'd6);

    // 6-pixel streaming frame with a 5-cycle sink stall
    out0 = n_out;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(i * 40, 255 - i * 30, i * 17, i == 0, i == 5);
      end
      begin
        repeat (2) @(posedge clk);
        #1 dut_if.m_ready = 1'b0;
        @(negedge clk);
        chk("stall_s_ready", 32'(dut_if.s_ready), 32'd0);
        repeat (5) @(posedge clk);
        #1 dut_if.m_ready = 1'b1;
      end
    join
    drain();
    chk("t5_out_count", 32'(n_out - out0), 32'd6);
    chk("t5_frame_cnt", 32'(frame_cnt), 32'd7);
    chk("t5_last_pix", 32'(last_frame_pixels), 32'd6);

    // drops while idle, then SOF inside an active frame
    out0 = n_out;
    for (int i = 0; i < 4; i++) send(10, 20, 30, 1'b0, 1'b0);
    drain();
    chk("t6_drop_cnt", 32'(drop_cnt), 32'd4);
    chk("t6_no_output", 32'(n_out - out0), 32'd0);
    chk("t6_err_clear", 32'(err_sof), 32'd0);
    send(100, 50, 200, 1'b1, 1'b0);
    send(0, 0, 0, 1'b0, 1'b0);
    send(100, 50, 200, 1'b1, 1'b0);
    chk("t6_err_set", 32'(err_sof), 32'd1);
    chk("t6_frame_not_counted", 32'(frame_cnt), 32'd7);
    send(255, 0, 0, 1'b0, 1'b0);
    send(0, 255, 0, 1'b0, 1'b1);
    drain();
    chk("t6_frame_cnt", 32'(frame_cnt), 32'd8);
    chk("t6_last_pix", 32'(last_frame_pixels), 32'd3);

    // cfg write coinciding with SOF takes effect on that SOF, and sticks in shadow
    send(100, 50, 200, 1'b1, 1'b1, 1'b1, 7);
    send(0, 0, 0, 1'b1, 1'b1);
    drain();
    chk("t7_frame_cnt", 32'(frame_cnt), 32'd10);
    chk("t7_drop_hold", 32'(drop_cnt), 32'd4);

    // reset mid-frame flushes the pipe and clears everything
    send(100, 50, 200, 1'b1, 1'b0);
    send(100, 50, 200, 1'b0, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    m_shadow = 0;
    m_active = 0;
    m_act    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_rst_m_valid", 32'(dut_if.m_valid), 32'd0);
    chk("mid_rst_s_ready", 32'(dut_if.s_ready), 32'd0);
    chk("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("mid_rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("mid_rst_err_sof", 32'(err_sof), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_last_pix", 32'(last_frame_pixels), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_s_ready_back", 32'(dut_if.s_ready), 32'd1);
    @(posedge clk);
    #1;
    send(100, 50, 200, 1'b1, 1'b1);
    drain();
    chk("t8_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("t8_last_pix", 32'(last_frame_pixels), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
